// File: rtl/a51_pkg.sv
// Shared constants and state encoding for the A5/1 stream cipher slice.
package a51_pkg;

  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;

  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h0_7200 << 4; // bits 13,16,17,18
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;      // bits 20,21
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;      // bits 7,20,21,22

  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  localparam int KEY_BITS   = 64;
  localparam int FRAME_BITS = 22;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_KEY   = 3'd1,
    ST_LOAD_FRAME = 3'd2,
    ST_WARMUP     = 3'd3,
    ST_GEN        = 3'd4,
    ST_DONE       = 3'd5
  } a51_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a51_lfsr_core.sv
// The three A5/1 shift registers with key/frame loading and majority clocking.
// ks_bit is the keystream bit the registers present after the current step.
module a51_lfsr_core
  import a51_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic step,
  input  logic load_mode,
  input  logic in_bit,
  output logic ks_bit
);

  logic [R1_LEN-1:0] r1, r1_nxt;
  logic [R2_LEN-1:0] r2, r2_nxt;
  logic [R3_LEN-1:0] r3, r3_nxt;
  logic              maj, inj;
  logic              en1, en2, en3;

  always_comb begin
    maj = maj3(r1[R1_CLK], r2[R2_CLK], r3[R3_CLK]);
    inj = load_mode & in_bit;
    // During loading every register clocks regardless of the majority vote
    en1 = step & (load_mode | (r1[R1_CLK] == maj));
    en2 = step & (load_mode | (r2[R2_CLK] == maj));
    en3 = step & (load_mode | (r3[R3_CLK] == maj));
    r1_nxt = en1 ? {r1[R1_LEN-2:0], (^(r1 & R1_TAPS)) ^ inj} : r1;
    r2_nxt = en2 ? {r2[R2_LEN-2:0], (^(r2 & R2_TAPS)) ^ inj} : r2;
    r3_nxt = en3 ? {r3[R3_LEN-2:0], (^(r3 & R3_TAPS)) ^ inj} : r3;
    ks_bit = r1_nxt[R1_LEN-1] ^ r2_nxt[R2_LEN-1] ^ r3_nxt[R3_LEN-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else if (clear) begin
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else begin
      r1 <= r1_nxt;
      r2 <= r2_nxt;
      r3 <= r3_nxt;
    end
  end

endmodule

// File: rtl/a51_stream_cipher.sv
// A5/1 pixel-stream encryptor/decryptor: sequencing FSM, keystream word buffer
// and valid/ready handshake around a51_lfsr_core.
//
// state         | meaning
// ST_IDLE       | waiting for start; key/frame captured on start
// ST_LOAD_KEY   | 64 forced clocks mixing in the key bits
// ST_LOAD_FRAME | 22 forced clocks mixing in the frame bits
// ST_WARMUP     | WARMUP_CYC majority clocks, output discarded
// ST_GEN        | filling keystream buffer / transferring words
// ST_DONE       | one-cycle done pulse after the last word
module a51_stream_cipher
  import a51_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_WORDS  = 65536,
  parameter int WARMUP_CYC = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [63:0]       key,
  input  logic [21:0]       frame,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int PH_MAX = (WARMUP_CYC > KEY_BITS) ? WARMUP_CYC : KEY_BITS;
  localparam int CNT_W  = $clog2(PH_MAX + 1);
  localparam int WC_W   = $clog2(NUM_WORDS + 1);
  localparam int BC_W   = $clog2(DATA_W + 1);
  localparam int WARM_LOAD = (WARMUP_CYC > 0) ? WARMUP_CYC - 1 : 0;

  a51_state_t        state;
  logic [63:0]       key_q;
  logic [21:0]       frame_q;
  logic [CNT_W-1:0]  ph_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [WC_W-1:0]   word_cnt;
  logic [DATA_W-1:0] ks_buf;
  logic              buf_full;

  logic              core_clear, core_step, core_load, core_in, ks_bit;
  logic              xfer;
  logic [5:0]        key_idx;
  logic [4:0]        frame_idx;

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign in_ready = (state == ST_GEN) && buf_full && (!out_valid || out_ready) && !abort;
  assign xfer     = in_valid && in_ready;

  // ph_cnt counts down, so the bit index is recovered from the remaining count
  assign key_idx   = 6'(KEY_BITS - 1) - ph_cnt[5:0];
  assign frame_idx = 5'(FRAME_BITS - 1) - ph_cnt[4:0];

  always_comb begin
    core_clear = (state == ST_IDLE) && start && !abort;
    core_step  = 1'b0;
    core_load  = 1'b0;
    core_in    = 1'b0;
    case (state)
      ST_LOAD_KEY: begin
        core_step = 1'b1;
        core_load = 1'b1;
        core_in   = key_q[key_idx];
      end
      ST_LOAD_FRAME: begin
        core_step = 1'b1;
        core_load = 1'b1;
        core_in   = frame_q[frame_idx];
      end
      ST_WARMUP: core_step = 1'b1;
      ST_GEN:    core_step = !buf_full;
      default:   core_step = 1'b0;
    endcase
    if (abort) core_step = 1'b0;
  end

  a51_lfsr_core u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (core_clear),
    .step      (core_step),
    .load_mode (core_load),
    .in_bit    (core_in),
    .ks_bit    (ks_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      key_q    <= '0;
      frame_q  <= '0;
      ph_cnt   <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      ks_buf   <= '0;
      buf_full <= 1'b0;
    end else if (abort) begin
      state    <= ST_IDLE;
      ph_cnt   <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      ks_buf   <= '0;
      buf_full <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            key_q    <= key;
            frame_q  <= frame;
            ph_cnt   <= CNT_W'(KEY_BITS - 1);
            bit_cnt  <= '0;
            word_cnt <= '0;
            buf_full <= 1'b0;
            state    <= ST_LOAD_KEY;
          end
        end
        ST_LOAD_KEY: begin
          if (ph_cnt == '0) begin
            ph_cnt <= CNT_W'(FRAME_BITS - 1);
            state  <= ST_LOAD_FRAME;
          end else begin
            ph_cnt <= ph_cnt - 1'b1;
          end
        end
        ST_LOAD_FRAME: begin
          if (ph_cnt == '0) begin
            ph_cnt <= CNT_W'(WARM_LOAD);
            state  <= (WARMUP_CYC > 0) ? ST_WARMUP : ST_GEN;
          end else begin
            ph_cnt <= ph_cnt - 1'b1;
          end
        end
        ST_WARMUP: begin
          if (ph_cnt == '0) state <= ST_GEN;
          else              ph_cnt <= ph_cnt - 1'b1;
        end
        ST_GEN: begin
          if (xfer) begin
            buf_full <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == WC_W'(NUM_WORDS - 1)) state <= ST_DONE;
          end else if (!buf_full) begin
            // First generated bit ends up in the MSB of the word
            ks_buf  <= (ks_buf << 1) | DATA_W'(ks_bit);
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BC_W'(DATA_W - 1)) buf_full <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register is decoupled from the FSM so a pending word survives abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ ks_buf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_a51_stream_cipher.sv
// Directed bench for a51_stream_cipher: known A5/1 vector, backpressure,
// round trip, frame end, abort and asynchronous reset.
module tb_a51_stream_cipher;

  localparam int BOUND = 1000;
  localparam logic [63:0] KV_KEY   = 64'hEFCD_AB89_6745_2312;
  localparam logic [21:0] KV_FRAME = 22'h134;
  localparam logic [7:0]  KV [0:5] = '{8'h53, 8'h4E, 8'hAA, 8'h58, 8'h2F, 8'hE8};

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [63:0] key = '0;
  logic [21:0] frame = '0;
  logic [7:0]  in_data = '0;

  logic       busy, done, in_ready, out_valid;
  logic [7:0] out_data;
  logic       busy4, done4, in_ready4, out_valid4;
  logic [7:0] out_data4;

  int checks = 0, errors = 0;
  int done_cnt = 0, done4_cnt = 0;
  logic [7:0] exp_q [$];
  logic [7:0] cap_q [$];
  logic [7:0] ks_model [0:15];
  logic [7:0] pt [0:15];
  logic [7:0] ct [0:15];
  logic [7:0] mon_exp;
  int bp_bad, ir_bad, d4_base;

  always #5 clk = ~clk;

  a51_stream_cipher #(.DATA_W(8), .NUM_WORDS(16), .WARMUP_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key(key), .frame(frame),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  a51_stream_cipher #(.DATA_W(8), .NUM_WORDS(4), .WARMUP_CYC(100)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key(key), .frame(frame),
    .busy(busy4), .done(done4), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every accepted output word pops one expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_with_empty_queue", exp_q.size(), 1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data", out_data, mon_exp);
        cap_q.push_back(out_data);
      end
    end
    if (rst_n && done)  done_cnt++;
    if (rst_n && done4) done4_cnt++;
  end

  // Bit-serial reference of A5/1 producing 16 keystream bytes
  task automatic run_model(input logic [63:0] k, input logic [21:0] f);
    logic [18:0] a;
    logic [21:0] b;
    logic [22:0] c;
    logic kb, m;
    int n;
    a = '0; b = '0; c = '0;
    for (int i = 0; i < 86; i++) begin
      if (i < 64) kb = k[i];
      else        kb = f[i-64];
      a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13] ^ kb};
      b = {b[20:0], b[21] ^ b[20] ^ kb};
      c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7] ^ kb};
    end
    for (int i = 0; i < 228; i++) begin
      m = (a[8] & b[10]) | (a[8] & c[10]) | (b[10] & c[10]);
      if (a[8]  == m) a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13]};
      if (b[10] == m) b = {b[20:0], b[21] ^ b[20]};
      if (c[10] == m) c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7]};
      if (i >= 100) begin
        n = i - 100;
        ks_model[n/8][7-(n%8)] = a[18] ^ b[21] ^ c[22];
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input logic [7:0] e);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("in_handshake_timeout", 32'(n < BOUND), 1);
    if (n < BOUND) exp_q.push_back(e);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_q_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("queue_drain_timeout", 32'(n < BOUND), 1);
    tick(1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < BOUND), 1);
    tick(1);
  endtask

  initial begin
    // Reset values
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);

    // Known vector with 20 cycles of backpressure after the first output
    key = KV_KEY; frame = KV_FRAME; out_ready = 1'b0;
    pulse_start();
    check("busy_after_start", busy, 1);
    send_word(8'h00, KV[0]);
    check("first_out_valid", out_valid, 1);
    in_valid = 1'b1; in_data = 8'h00;
    bp_bad = 0; ir_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== KV[0]) bp_bad++;
      if (in_ready !== 1'b0) ir_bad++;
    end
    check("bp_out_hold", bp_bad, 0);
    check("bp_in_ready_low", ir_bad, 0);
    tick(1);
    out_ready = 1'b1;
    for (int i = 1; i < 6; i++) send_word(8'h00, KV[i]);
    wait_q_empty();
    pulse_abort();
    check("busy_after_abort", busy, 0);

    // Round trip with random key/frame/data
    key = {$urandom, $urandom}; frame = 22'($urandom);
    run_model(key, frame);
    for (int i = 0; i < 16; i++) pt[i] = 8'($urandom);
    cap_q.delete(); done_cnt = 0;
    pulse_start();
    for (int i = 0; i < 16; i++) send_word(pt[i], pt[i] ^ ks_model[i]);
    wait_q_empty();
    wait_idle();
    check("enc_done_once", done_cnt, 1);
    check("enc_capture_count", cap_q.size(), 16);
    for (int i = 0; i < 16; i++) ct[i] = (i < cap_q.size()) ? cap_q[i] : 8'h00;
    pulse_start();
    for (int i = 0; i < 16; i++) send_word(ct[i], pt[i]);
    wait_q_empty();
    wait_idle();
    check("dec_done_once", done_cnt, 2);

    // Frame end on the NUM_WORDS=4 instance, with a start while busy
    key = KV_KEY; frame = KV_FRAME;
    d4_base = done4_cnt;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_word(8'(8'h11 * i), KV[i] ^ 8'(8'h11 * i));
      check("fe_out_data4", out_data4, KV[i] ^ 8'(8'h11 * i));
      if (i == 1) begin
        pulse_start();
        check("fe_busy_during_start", busy4, 1);
      end
      if (i == 2) check("fe_no_early_done", done4, 0);
    end
    check("fe_done_pulse", done4, 1);
    check("fe_busy_in_done", busy4, 1);
    tick(1);
    check("fe_done_cleared", done4, 0);
    check("fe_busy_fell", busy4, 0);
    check("fe_done_count", done4_cnt - d4_base, 1);
    wait_q_empty();
    pulse_abort();

    // Abort in GEN keeps the pending word; abort in WARMUP then restart
    out_ready = 1'b0;
    pulse_start();
    send_word(8'h00, KV[0]);
    tick(3);
    pulse_abort();
    check("abort_keeps_valid", out_valid, 1);
    check("abort_keeps_data", out_data, KV[0]);
    check("abort_busy_low", busy, 0);
    out_ready = 1'b1;
    wait_q_empty();
    pulse_start();
    tick(99);
    abort = 1'b1; start = 1'b1;
    tick(1);
    check("abort_in_warmup", busy, 0);
    tick(1);
    check("abort_start_same_cycle", busy, 0);
    abort = 1'b0; start = 1'b0;
    pulse_start();
    for (int i = 0; i < 6; i++) send_word(8'h00, KV[i]);
    wait_q_empty();
    pulse_abort();

    // Asynchronous reset in the middle of GEN
    out_ready = 1'b0;
    pulse_start();
    send_word(8'h00, KV[0]);
    tick(4);
    check("pre_reset_pending", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_in_ready", in_ready, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_data", out_data, 0);
    check("async_rst_out_valid4", out_valid4, 0);
    exp_q.delete();
    tick(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(3);
    check("post_reset_idle", busy, 0);
    check("post_reset_no_output", out_valid, 0);
    check("post_reset_in_ready4", in_ready4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/a51_stream_cipher.md
Name: a51_stream_cipher

Overview:
- Parametrised A5/1 keystream encryptor/decryptor for image pixel streams; the next generation of the team's serial A5/1 block.
- Adds explicit reset, start/busy/done control, 64-bit key and 22-bit frame ports, standard majority clocking, a configurable word width and frame length, and valid/ready streaming with backpressure.
- Sits between the pixel source (image ROM/BRAM reader) and the sink. Encryption and decryption are the same XOR operation.

Parameters:
- DATA_W, 8, pixel word width in bits; each word consumes DATA_W keystream bits.
- NUM_WORDS, 65536, words per frame before done; 65536 x 8 = 524288 bits.
- WARMUP_CYC, 100, majority-clocked cycles discarded before keystream output.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  synchronous return to IDLE from any state.
- key  in  64  session key; bit i = key[8*(i/8) + (i%8)], byte 0 is key[7:0].
- frame  in  22  frame number; bit i = frame[i].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the frame completes.
- in_valid  in  1  pixel input valid.
- in_ready  out  1  pixel input ready.
- in_data  in  DATA_W  plaintext or ciphertext word.
- out_valid  out  1  result valid.
- out_ready  in  1  sink ready.
- out_data  out  DATA_W  in_data XOR keystream word.

Behaviour:
- Reset is asynchronous and active-low. All LFSRs, counters, buffers and the FSM clear. Outputs under reset: busy=0, done=0, in_ready=0, out_valid=0, out_data=0.
- Registers: R1 is 19 bits (taps 13,16,17,18; clock bit 8). R2 is 22 bits (taps 20,21; clock bit 10). R3 is 23 bits (taps 7,20,21,22; clock bit 10).
- Shift rule: shift toward the MSB; feedback enters bit 0; the output bit is the MSB.
- FSM states: IDLE -> LOAD_KEY -> LOAD_FRAME -> WARMUP -> GEN -> DONE -> IDLE.
- IDLE:
  - On start, the key and frame are captured into internal registers.
  - All three registers clear, and the FSM moves to LOAD_KEY.
- LOAD_KEY: 64 cycles. Every register clocks, with feedback = taps XOR key bit i for i = 0..63.
- LOAD_FRAME: 22 cycles, same rule using frame bit i.
- WARMUP: WARMUP_CYC cycles of majority clocking; output is discarded.
  - maj = majority(R1[8], R2[10], R3[10]).
  - A register shifts only if its clock bit equals maj. Feedback is taps only.
- GEN, keystream bit generation:
  - Each generation cycle performs one majority clock.
  - ks = R1[18] ^ R2[21] ^ R3[22], taken after that clock.
  - Bits fill the keystream buffer MSB first: the first bit pairs with in_data[DATA_W-1].
  - After DATA_W bits the buffer is full, and the core stalls (no clocking) until the word is consumed.
- GEN, word transfer:
  - in_ready = buf_full && (!out_valid || out_ready).
  - A transfer occurs on in_valid && in_ready: out_data <= in_data ^ ks_buf, out_valid <= 1, buf_full clears, and generation resumes the next cycle.
  - Sustained throughput is one word per DATA_W+1 cycles.
- Output hold: out_valid and out_data hold until out_ready. They are independent of the FSM and may still be pending in DONE/IDLE.
- Frame end: a word counter (width clog2(NUM_WORDS+1)) increments per transfer. The transfer of word NUM_WORDS-1 moves the FSM to DONE.
- DONE: lasts one cycle, asserts done=1, then goes to IDLE.
- Latency: with start sampled in cycle 0, the first keystream buffer is full at cycle 86 + WARMUP_CYC + DATA_W (194 with defaults). in_ready can rise in that cycle.
- Boundary conditions:
  - start while busy is ignored.
  - abort has priority over every other event. It clears the FSM, buffer and counter but leaves a pending output word intact.
  - abort and start in the same cycle: abort wins, and start is ignored.
  - A mid-frame reset drops all state, including the pending output.
  - in_valid while in_ready=0 is held by the source; no data is dropped.

Decomposition:
- Package a51_pkg holds:
  - R1_LEN/R2_LEN/R3_LEN;
  - tap masks;
  - clock-bit indices (8, 10, 10);
  - KEY_BITS=64 and FRAME_BITS=22;
  - an FSM state enum.
- One sub-module, a51_lfsr_core. It contains the three registers and has step, load_mode and in_bit inputs and a ks_bit output.
- The top level holds the FSM, counters, keystream buffer and the handshake.

Test Plan:
- Known vector:
  - Stimulus: key=64'hEFCD_AB89_6745_2312, frame=22'h134, DATA_W=8, in_data=0, out_ready=1.
  - Response: first out_data words are 8'h53, 8'h4E, 8'hAA, 8'h58, 8'h2F, 8'hE8.
- Round trip:
  - Stimulus: encrypt 16 random words, then restart with the same key and frame and feed the ciphertext back.
  - Response: the original words are returned exactly, and done pulses once per run.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after the first output.
  - Response: out_data stays stable, in_ready=0, and no keystream bits are consumed. The released sequence matches the known vector.
- Frame end:
  - Stimulus: NUM_WORDS=4.
  - Response: done pulses exactly one cycle after the 4th transfer, busy falls, and a start during busy has no effect.
- Abort and reset:
  - Stimulus: abort at cycle 100 (in WARMUP), then start again.
  - Response: output matches the known vector from the beginning.
  - Stimulus: assert rst_n=0 mid-GEN.
  - Response: all outputs go to 0 immediately, without waiting for a clock edge.
